adc_scan_ctrl: RTL and testbench

SAR conversion sequencer for the analog top's shared comparator path. It selects one comparator input through the one-hot CMP_SEL bus and drives AD_RST/AD_HOLD. It then runs a DW-bit successive approximation on DAC1 using COMP_O. Channels are scanned round-robin over a software mask, and a single-shot request can pre-empt the scan at channel boundaries.

---
 rtl/adc_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_adc_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: SAR sequencer with round-robin/one-shot channel arbitration; define ADC_AVG4_EN for 4x averaging per grant
module adc_scan_ctrl #(
  parameter int NCH = 16,
  parameter int DW = 10,
  parameter int SETTLE_CYC = 8,
  parameter int CMP_CYC = 3
) (
  input  logic           clk,
  input  logic           rstz,
  input  logic           scan_en,
  input  logic [NCH-1:0] ch_mask,
  input  logic           os_req,
  input  logic [3:0]     os_ch,
  output logic           os_ack,
  output logic [NCH-1:0] cmp_sel,
  output logic [DW-1:0]  dac1,
  output logic           dac1_en,
  output logic           ad_rst,
  output logic           ad_hold,
  input  logic           comp_o,
  output logic [DW-1:0]  res_dat,
  output logic [3:0]     res_ch,
  output logic           res_vld,
  output logic           busy
);
  localparam int CMAX = SETTLE_CYC > CMP_CYC ? SETTLE_CYC : CMP_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = $clog2(DW);
  typedef enum logic [2:0] {IDLE, SEL, HOLD, CONV, DONE} state_t;
  state_t state, nxt;
  logic [1:0] sync;
  logic comp_s, is_os, scan_hit, os_ok, arb, grant, abort, cmp_last, conv_end, last_conv;
  logic [3:0] ptr, ch, scan_ch, gch;
  logic [NCH-1:0] dm;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bi;
  logic [DW-1:0] code, trial, code_nxt, res_nxt;
  assign comp_s = sync[1];
  always_comb begin
    dm = NCH'({ch_mask, ch_mask} >> ptr >> 1);
    scan_hit = 1'b0;
    scan_ch = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (dm[k]) begin
        scan_hit = 1'b1;
        scan_ch = 4'((int'(ptr) + 1 + k) % NCH);
      end
  end
  always_comb begin
    arb = rstz && (state == IDLE || state == DONE);
    os_ok = int'(os_ch) < NCH;
    grant = os_req ? os_ok : scan_en && scan_hit;
    gch = os_req ? os_ch : scan_ch;
    abort = !is_os && !scan_en && (state == SEL || state == HOLD || state == CONV);
    cmp_last = state == CONV && cnt == CW'(CMP_CYC - 1);
    conv_end = cmp_last && bi == '0;
    trial = code | (DW'(1) << bi);
    code_nxt = comp_s ? trial : code;
    nxt = state;
    if (arb) nxt = grant ? SEL : IDLE;
    else if (abort) nxt = IDLE;
    else if (state == SEL) nxt = cnt == CW'(SETTLE_CYC - 1) ? HOLD : SEL;
    else if (state == HOLD) nxt = CONV;
    else if (conv_end) nxt = last_conv ? DONE : HOLD;
  end
  always_ff @(posedge clk) state <= !rstz ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!rstz) begin
      sync <= '0;
      ptr <= '0;
      ch <= '0;
      is_os <= 1'b0;
      cnt <= '0;
      bi <= '0;
      code <= '0;
      res_dat <= '0;
      res_ch <= '0;
    end else begin
      sync <= {sync[0], comp_o};
      cnt <= (nxt != state || cmp_last) ? '0 : cnt + 1'b1;
      if (arb && grant) begin
        ch <= gch;
        is_os <= os_req;
        code <= '0;
        if (!os_req) ptr <= scan_ch;
      end
      if (state == HOLD) bi <= BW'(DW - 1);
      if (cmp_last) begin
        bi <= bi - 1'b1;
        code <= conv_end && !last_conv ? '0 : code_nxt;
      end
      if (conv_end && last_conv && !abort) begin
        res_dat <= res_nxt;
        res_ch <= ch;
      end
    end
  end
`ifdef ADC_AVG4_EN
  logic [1:0] rep;
  logic [DW+1:0] acc, sum;
  always_comb begin
    last_conv = rep == 2'd3;
    sum = acc + (DW+2)'(code_nxt);
    res_nxt = sum[DW+1:2];
  end
  always_ff @(posedge clk) begin
    if (!rstz || (arb && grant)) begin
      rep <= '0;
      acc <= '0;
    end else if (conv_end) begin
      rep <= rep + 1'b1;
      acc <= sum;
    end
  end
`else
  always_comb begin
    last_conv = 1'b1;
    res_nxt = code_nxt;
  end
`endif
  always_comb begin
    busy = state != IDLE;
    os_ack = arb && os_req;
    res_vld = state == DONE;
    cmp_sel = busy ? NCH'(1) << ch : '0;
    dac1_en = busy;
    ad_rst = state == SEL;
    ad_hold = state == HOLD || state == CONV;
    dac1 = state == CONV ? trial : busy ? code : '0;
  end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: table-driven and scoreboard bench for adc_scan_ctrl
module tb_adc_scan_ctrl;
  localparam int NCH = 8, DW = 10, SETTLE = 8, CMPC = 3;
`ifdef ADC_AVG4_EN
  localparam int LAT = SETTLE + 4 * (1 + DW * CMPC) + 1;
`else
  localparam int LAT = SETTLE + 1 + DW * CMPC + 1;
`endif
  logic clk = 1'b0, rstz = 1'b0, scan_en = 1'b0, os_req = 1'b0, comp_o;
  logic [NCH-1:0] ch_mask = '0;
  logic [3:0] os_ch = '0;
  logic os_ack, dac1_en, ad_rst, ad_hold, res_vld, busy;
  logic [NCH-1:0] cmp_sel;
  logic [DW-1:0] dac1, res_dat;
  logic [3:0] res_ch;
  logic [DW-1:0] vin [NCH];
  logic alt_mode = 1'b0, alt = 1'b0;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [3:0] ch; logic [DW-1:0] dat; } res_t;
  typedef struct { logic [3:0] ch; logic [DW-1:0] v; bit vld; logic [DW-1:0] exp; } vec_t;
  res_t exp_q [$];
  res_t e;
  vec_t tbl [8];
  always #5 clk = ~clk;
  adc_scan_ctrl #(.NCH(NCH), .DW(DW), .SETTLE_CYC(SETTLE), .CMP_CYC(CMPC)) dut (
    .clk(clk), .rstz(rstz), .scan_en(scan_en), .ch_mask(ch_mask), .os_req(os_req),
    .os_ch(os_ch), .os_ack(os_ack), .cmp_sel(cmp_sel), .dac1(dac1), .dac1_en(dac1_en),
    .ad_rst(ad_rst), .ad_hold(ad_hold), .comp_o(comp_o), .res_dat(res_dat),
    .res_ch(res_ch), .res_vld(res_vld), .busy(busy)
  );
  always_comb begin
    comp_o = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (cmp_sel[i]) comp_o = ((alt_mode && i == 1) ? (alt ? 10'h103 : 10'h100) : vin[i]) >= dac1;
  end
  always @(posedge clk) if (alt_mode && ad_hold && dac1 == '0) alt <= !alt;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (res_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_res_vld: got ch %0d dat %0h, expected no result", res_ch, res_dat);
      end else begin
        e = exp_q.pop_front();
        check("res_ch", 32'(res_ch), 32'(e.ch));
        check("res_dat", 32'(res_dat), 32'(e.dat));
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input logic [3:0] ch, input logic [DW-1:0] dat);
    res_t r;
    r.ch = ch;
    r.dat = dat;
    exp_q.push_back(r);
  endtask
  task automatic wait_vld(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!res_vld && n < 400);
    if (!res_vld) begin
      n_chk++;
      n_fail++;
      $display("FAIL res_vld_timeout: no res_vld after %0d cycles, expected one", n);
    end
  endtask
  task automatic wait_ack(input int lim, output bit seen);
    seen = os_ack;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      seen = os_ack;
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_cmp_sel"}, 32'(cmp_sel), 0);
    check({tag, "_dac1"}, 32'(dac1), 0);
    check({tag, "_dac1_en"}, 32'(dac1_en), 0);
    check({tag, "_ad_rst"}, 32'(ad_rst), 0);
    check({tag, "_ad_hold"}, 32'(ad_hold), 0);
    check({tag, "_res_vld"}, 32'(res_vld), 0);
    check({tag, "_os_ack"}, 32'(os_ack), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, lat;
    logic [DW-1:0] first, last;
    bit seen;
    tbl[0] = '{4'd1, 10'h3FF, 1'b1, 10'h3FF};
    tbl[1] = '{4'd4, 10'h000, 1'b1, 10'h000};
    tbl[2] = '{4'd0, 10'h2A5, 1'b1, 10'h2A5};
    tbl[3] = '{4'd7, 10'h200, 1'b1, 10'h200};
    tbl[4] = '{4'd6, 10'h1FF, 1'b1, 10'h1FF};
    tbl[5] = '{4'd2, 10'h001, 1'b1, 10'h001};
    tbl[6] = '{4'd15, 10'h0, 1'b0, 10'h0};
    tbl[7] = '{4'd8, 10'h0, 1'b0, 10'h0};
    for (int i = 0; i < NCH; i++) vin[i] = '0;
    last = '0;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_res_dat", 32'(res_dat), 0);
    check("reset_res_ch", 32'(res_ch), 0);
    rstz = 1'b1;
    tick();
    foreach (tbl[i]) begin
      if (tbl[i].vld) vin[tbl[i].ch[2:0]] = tbl[i].v;
      os_ch = tbl[i].ch;
      os_req = 1'b1;
      #1;
      check("os_ack", 32'(os_ack), 1);
      tick();
      os_req = 1'b0;
      if (tbl[i].vld) begin
        push_exp(tbl[i].ch, tbl[i].exp);
        lat = 1;
        first = '0;
        while (!res_vld && lat < 400) begin
          if (first == '0 && dac1 != '0) first = dac1;
          tick();
          lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        check("first_trial", 32'(first), 32'h200);
        check("dac1_final", 32'(dac1), 32'(tbl[i].exp));
        last = tbl[i].exp;
        tick();
        check("res_vld_pulse", 32'(res_vld), 0);
        check("idle_after_os", 32'(busy), 0);
      end else begin
        check("bad_os_idle", 32'(busy), 0);
        repeat (50) tick();
        check("bad_os_res_hold", 32'(res_dat), 32'(last));
      end
    end
    vin[0] = 10'h2A5;
    vin[2] = 10'h001;
    push_exp(4'd2, 10'h001);
    push_exp(4'd0, 10'h2A5);
    push_exp(4'd2, 10'h001);
    ch_mask = 8'h05;
    scan_en = 1'b1;
    wait_vld(n);
    check("scan_lat0", 32'(n), 32'(LAT));
    wait_vld(n);
    check("scan_period1", 32'(n), 32'(LAT));
    wait_vld(n);
    check("scan_period2", 32'(n), 32'(LAT));
    scan_en = 1'b0;
    tick();
    check("scan_stop", 32'(busy), 0);
    vin[3] = 10'h155;
    vin[5] = 10'h0AA;
    vin[7] = 10'h3C3;
    push_exp(4'd3, 10'h155);
    push_exp(4'd7, 10'h3C3);
    push_exp(4'd5, 10'h0AA);
    ch_mask = 8'h28;
    scan_en = 1'b1;
    repeat (20) tick();
    os_ch = 4'd7;
    os_req = 1'b1;
    wait_ack(100, seen);
    check("os_ack_mid", 32'(seen), 1);
    check("ack_in_done", 32'(res_vld), 1);
    check("ack_done_ch", 32'(res_ch), 3);
    tick();
    os_req = 1'b0;
    check("os_sel_ch7", 32'(cmp_sel), 32'h80);
    wait_vld(n);
    check("os_lat", 32'(n), 32'(LAT - 1));
    wait_vld(n);
    check("resume_period", 32'(n), 32'(LAT));
    scan_en = 1'b0;
    tick();
    check("resume_stop", 32'(busy), 0);
    ch_mask = 8'h01;
    scan_en = 1'b1;
    repeat (20) tick();
    check("abort_in_conv", 32'(ad_hold), 1);
    scan_en = 1'b0;
    tick();
    check_quiet("abort");
    repeat (60) tick();
    check("abort_res_hold", 32'(res_dat), 32'h0AA);
    check("abort_ch_hold", 32'(res_ch), 5);
    os_ch = 4'd0;
    os_req = 1'b1;
    tick();
    os_req = 1'b0;
    repeat (20) tick();
    check("rst_in_conv", 32'(ad_hold), 1);
    rstz = 1'b0;
    tick();
    check_quiet("rst_conv");
    check("rst_res_dat", 32'(res_dat), 0);
    check("rst_res_ch", 32'(res_ch), 0);
    repeat (2) tick();
    rstz = 1'b1;
    tick();
`ifdef ADC_AVG4_EN
    alt_mode = 1'b1;
    push_exp(4'd1, 10'h101);
    os_ch = 4'd1;
    os_req = 1'b1;
    tick();
    os_req = 1'b0;
    wait_vld(n);
    check("avg_lat", 32'(n), 32'(LAT - 1));
    tick();
    check("avg_single_vld", 32'(res_vld), 0);
    alt_mode = 1'b0;
`endif
    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
